// File: rtl/instr_pkg.sv
// Shared types, constants and helpers for the instrumentation output sink.
// Optional stall LFSR constants are used only when INSTR_SINK_BACKPRESSURE_EN is defined.
package instr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } sink_state_e;

    localparam int CKSUM_W     = 24;
    localparam int IDX_W       = 8;
    localparam int MAX_DATA_W  = 1024;
    localparam int FOLD_SLICES = (MAX_DATA_W + CKSUM_W - 1) / CKSUM_W;

    // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // XOR of consecutive 24-bit slices; the top slice is zero-padded.
    function automatic logic [CKSUM_W-1:0] fold24(input logic [MAX_DATA_W-1:0] d);
        logic [FOLD_SLICES*CKSUM_W-1:0] padded;
        logic [CKSUM_W-1:0]             acc;
        padded                   = '0;
        padded[MAX_DATA_W-1:0]   = d;
        acc                      = '0;
        for (int i = 0; i < FOLD_SLICES; i++) begin
            acc = acc ^ padded[i*CKSUM_W +: CKSUM_W];
        end
        return acc;
    endfunction

    function automatic logic [CKSUM_W-1:0] rotl24(input logic [CKSUM_W-1:0] x);
        return {x[CKSUM_W-2:0], x[CKSUM_W-1]};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/instr_checksum_acc.sv
// Rotate-XOR frame accumulator: folds each accepted beat into a running
// 24-bit sum and, on the last beat of a frame, publishes {frame_idx, sum}.
module instr_checksum_acc
    import instr_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_BEATS = 64
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  clear,
    input  logic                  beat,
    input  logic [DATA_WIDTH-1:0] tdata,
    output logic                  frame_close,
    output logic [31:0]           checksum
);

    localparam int               BIF_W     = $clog2(FRAME_BEATS + 1);
    localparam logic [BIF_W-1:0] LAST_BEAT = BIF_W'(FRAME_BEATS - 1);

    logic [CKSUM_W-1:0]    sum;
    logic [CKSUM_W-1:0]    new_sum;
    logic [BIF_W-1:0]      beat_in_frame;
    logic [IDX_W-1:0]      frame_idx;
    logic [MAX_DATA_W-1:0] wide_data;

    assign frame_close = beat && (beat_in_frame == LAST_BEAT);

    // Next running sum for the beat currently on the bus.
    always_comb begin
        wide_data = MAX_DATA_W'(tdata);
        new_sum   = rotl24(sum) ^ fold24(wide_data);
    end

    // Accumulate beats; close the frame on its last beat. Clear outranks a beat.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sum           <= '0;
            beat_in_frame <= '0;
            frame_idx     <= '0;
            checksum      <= '0;
        end else if (clear) begin
            sum           <= '0;
            beat_in_frame <= '0;
            frame_idx     <= '0;
            checksum      <= '0;
        end else if (beat) begin
            if (frame_close) begin
                checksum      <= {frame_idx, new_sum};
                sum           <= '0;
                beat_in_frame <= '0;
                frame_idx     <= frame_idx + 1'b1;
            end else begin
                sum           <= new_sum;
                beat_in_frame <= beat_in_frame + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_output_sink.sv
// Output-side instrumentation sink: accepts DUT output beats, counts them,
// measures first-frame latency and frame interval, and tags frame checksums.
// Optional feature: define INSTR_SINK_BACKPRESSURE_EN to add an LFSR stall mask on s_axis_tready.
module instr_output_sink
    import instr_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_BEATS = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  in_start,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [CNT_WIDTH-1:0]  status_o,
    output logic [CNT_WIDTH-1:0]  latency,
    output logic [CNT_WIDTH-1:0]  interval,
    output logic [31:0]           checksum
);

    sink_state_e          state, state_next;
    logic                 beat;
    logic                 frame_close;
    logic                 take_latency;
    logic                 lat_started;
    logic [CNT_WIDTH-1:0] lat_cnt;
    logic                 iv_started;
    logic [CNT_WIDTH-1:0] iv_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Ready is held low during reset and clear so a coincident beat is never accepted.
`ifdef INSTR_SINK_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // Stall-mask LFSR, advancing only while the sink is enabled.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            lfsr <= LFSR_SEED;
        end else if (clear) begin
            lfsr <= LFSR_SEED;
        end else if (enable) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign s_axis_tready = enable & ~lfsr[0] & ~ap_rst & ~clear;
`else
    assign s_axis_tready = enable & ~ap_rst & ~clear;
`endif

    assign beat = s_axis_tvalid & s_axis_tready;

    // State register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; the first accepted beat (even in IDLE) captures latency and enters RUN.
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next   = state;
        take_latency = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_next   = beat ? RUN : ARMED;
                    take_latency = beat;
                end
            end
            ARMED: begin
                if (beat) begin
                    state_next   = RUN;
                    take_latency = 1'b1;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Beat, latency and interval counters; all frozen while enable is low.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            status_o    <= '0;
            latency     <= '0;
            interval    <= '0;
            lat_started <= 1'b0;
            lat_cnt     <= '0;
            iv_started  <= 1'b0;
            iv_cnt      <= '0;
        end else if (clear) begin
            status_o    <= '0;
            latency     <= '0;
            interval    <= '0;
            lat_started <= 1'b0;
            lat_cnt     <= '0;
            iv_started  <= 1'b0;
            iv_cnt      <= '0;
        end else if (enable) begin
            if (beat) begin
                status_o <= sat_inc(status_o);
            end

            if (take_latency) begin
                latency <= lat_started ? lat_cnt : '0;
            end

            // The in_start cycle itself is cycle 0 of the latency count.
            if (state != RUN) begin
                if (lat_started) begin
                    lat_cnt <= sat_inc(lat_cnt);
                end else if (in_start) begin
                    lat_started <= 1'b1;
                    lat_cnt     <= CNT_WIDTH'(1);
                end
            end

            if (frame_close) begin
                if (iv_started) begin
                    interval <= iv_cnt;
                end
                iv_started <= 1'b1;
                iv_cnt     <= CNT_WIDTH'(1);
            end else if (iv_started) begin
                iv_cnt <= sat_inc(iv_cnt);
            end
        end
    end

    instr_checksum_acc #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAME_BEATS (FRAME_BEATS)
    ) u_acc (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .clear       (clear),
        .beat        (beat),
        .tdata       (s_axis_tdata),
        .frame_close (frame_close),
        .checksum    (checksum)
    );

endmodule

// File: tb/tb_instr_output_sink.sv
// Self-checking bench for instr_output_sink: directed scenarios plus a random
// phase, all scored against a cycle-indexed behavioural model.
module tb_instr_output_sink;

    localparam int DATA_WIDTH  = 32;
    localparam int FRAME_BEATS = 4;
    localparam int CNT_WIDTH   = 32;

    logic                  ap_clk = 1'b0;
    logic                  ap_rst = 1'b1;
    logic                  enable = 1'b0;
    logic                  clear = 1'b0;
    logic                  in_start = 1'b0;
    logic [DATA_WIDTH-1:0] s_axis_tdata = '0;
    logic                  s_axis_tvalid = 1'b0;
    logic                  s_axis_tready;
    logic [CNT_WIDTH-1:0]  status_o, latency, interval;
    logic [31:0]           checksum;

    int errors = 0;
    int checks = 0;

    instr_output_sink #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAME_BEATS (FRAME_BEATS),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .enable        (enable),
        .clear         (clear),
        .in_start      (in_start),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .status_o      (status_o),
        .latency       (latency),
        .interval      (interval),
        .checksum      (checksum)
    );

    always #5 ap_clk = ~ap_clk;

    // ---------------- behavioural model ----------------
    // Time is measured in enabled cycles; events are recorded by cycle index.
    int          en_cyc;
    int          start_c;
    int          last_done_c;
    int          frames;
    bit          first_beat_seen;
    logic [31:0] m_status, m_lat, m_iv, m_cks;
    logic [31:0] fq[$];
    logic [15:0] m_lfsr;

    function automatic logic [23:0] frame_sum(input logic [31:0] words[$]);
        logic [23:0] s;
        logic [23:0] f;
        s = '0;
        foreach (words[i]) begin
            f = words[i][23:0] ^ {16'h0, words[i][31:24]};
            s = {s[22:0], s[23]} ^ f;
        end
        return s;
    endfunction

    task automatic model_reset();
        en_cyc          = 0;
        start_c         = -1;
        last_done_c     = -1;
        frames          = 0;
        first_beat_seen = 1'b0;
        m_status        = '0;
        m_lat           = '0;
        m_iv            = '0;
        m_cks           = '0;
        fq.delete();
        m_lfsr          = 16'hACE1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check ready, advance the model, clock, then check outputs.
    task automatic tick();
        logic exp_rdy;
        logic beat;
        #1;
        exp_rdy = enable && !ap_rst && !clear;
`ifdef INSTR_SINK_BACKPRESSURE_EN
        exp_rdy = exp_rdy && !m_lfsr[0];
`endif
        check("tready", s_axis_tready, exp_rdy);
        beat = exp_rdy && s_axis_tvalid;

        if (ap_rst || clear) begin
            model_reset();
        end else if (enable) begin
            if (beat && !first_beat_seen) begin
                m_lat           = (start_c >= 0) ? 32'(en_cyc - start_c) : 32'd0;
                first_beat_seen = 1'b1;
            end
            if (in_start && start_c < 0 && !first_beat_seen) begin
                start_c = en_cyc;
            end
            if (beat) begin
                m_status++;
                fq.push_back(s_axis_tdata);
                if (fq.size() == FRAME_BEATS) begin
                    m_cks = {8'(frames % 256), frame_sum(fq)};
                    frames++;
                    fq.delete();
                    if (last_done_c >= 0) begin
                        m_iv = 32'(en_cyc - last_done_c);
                    end
                    last_done_c = en_cyc;
                end
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            en_cyc++;
        end

        @(posedge ap_clk);
        #1;
        check("status_o", status_o, m_status);
        check("latency",  latency,  m_lat);
        check("interval", interval, m_iv);
        check("checksum", checksum, m_cks);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [31:0] stall_data[4];

    initial begin
        model_reset();

        // 1: reset held with valid asserted
        enable        = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEADBEEF;
        ap_rst        = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ap_rst        = 1'b0;
        s_axis_tvalid = 1'b0;

        // 2: latency from in_start at cycle 10 to first beat at cycle 27
        for (int cyc = 0; cyc <= 27; cyc++) begin
            in_start      = (cyc == 10);
            s_axis_tvalid = (cyc == 27);
            s_axis_tdata  = 32'(cyc);
            tick();
        end
        in_start      = 1'b0;
        s_axis_tvalid = 1'b0;
        check("latency_17", latency, 17);
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_start      = (cyc == 2);
            s_axis_tvalid = (cyc == 4);
            tick();
        end
        in_start      = 1'b0;
        s_axis_tvalid = 1'b0;
        check("latency_held", latency, 17);

        // 3: one frame of 1,2,3,4
        pulse_clear();
        for (int i = 1; i <= 4; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'(i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        tick();
        check("frame1_status", status_o, 4);
        check("frame1_tag", checksum[31:24], 0);
        check("frame1_sum", checksum[23:0], frame_sum('{32'd1, 32'd2, 32'd3, 32'd4}));

        // 4: frame tag after 48 frames and after wrap
        pulse_clear();
        for (int n = 0; n < 2000 && frames < 48; n++) begin
            s_axis_tvalid = ($urandom_range(0, 9) < 7);
            s_axis_tdata  = $urandom;
            tick();
        end
        s_axis_tvalid = 1'b0;
        tick();
        check("tag_47", checksum[31:24], 47);
        for (int n = 0; n < 8000 && frames < 257; n++) begin
            s_axis_tvalid = ($urandom_range(0, 9) < 7);
            s_axis_tdata  = $urandom;
            tick();
        end
        s_axis_tvalid = 1'b0;
        tick();
        check("tag_wrap", checksum[31:24], 0);

        // 5: frames completing at cycles 100, 164, 240
        pulse_clear();
        for (int cyc = 0; cyc <= 245; cyc++) begin
            s_axis_tvalid = (cyc >= 97 && cyc <= 100) || (cyc >= 161 && cyc <= 164) ||
                            (cyc >= 237 && cyc <= 240);
            s_axis_tdata  = $urandom;
            tick();
            if (cyc == 100) check("interval_first", interval, 0);
            if (cyc == 164) check("interval_64", interval, 64);
            if (cyc == 240) check("interval_76", interval, 76);
        end
        s_axis_tvalid = 1'b0;

        // 6a: enable dropped mid-frame for 20 cycles
        pulse_clear();
        foreach (stall_data[i]) stall_data[i] = $urandom;
        for (int i = 0; i < 2; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = stall_data[i];
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = $urandom;
            tick();
        end
        check("stall_frozen", status_o, 2);
        enable = 1'b1;
        for (int i = 2; i < 4; i++) begin
            s_axis_tdata = stall_data[i];
            tick();
        end
        s_axis_tvalid = 1'b0;
        tick();
        check("stall_sum", checksum[23:0],
              frame_sum('{stall_data[0], stall_data[1], stall_data[2], stall_data[3]}));

        // 6b: clear coincident with a beat
        s_axis_tvalid = 1'b1;
        clear         = 1'b1;
        tick();
        clear         = 1'b0;
        s_axis_tvalid = 1'b0;
        check("clr_status", status_o, 0);
        check("clr_cks", checksum, 0);

        // random phase
        for (int n = 0; n < 3000; n++) begin
            enable        = ($urandom_range(0, 9) != 0);
            s_axis_tvalid = ($urandom_range(0, 9) < 6);
            in_start      = ($urandom_range(0, 19) == 0);
            clear         = ($urandom_range(0, 149) == 0);
            s_axis_tdata  = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
